cmp_sweep_driver: RTL and testbench

- Stimulus-and-check initiator for the 4-bit interleaved magnitude-comparator user module; it drives the comparator's 8-bit input bus and reads back its gt/lt/eq flags.
- On start, it sweeps every A/B operand pair, waits a settle window, samples the flags and checks them against an internal reference.
- Reports pass/fail, a saturating error count and the first failing vector.
- Sits beside the comparator on the same Tiny Tapeout tile, or drives an external comparator through io pins.

---
 rtl/cmp_sweep_pkg.sv | 35 +++
 rtl/cmp_flag_sync.sv | 26 ++
 rtl/cmp_sweep_driver.sv | 155 +++++++++++++++
 tb/tb_cmp_sweep_driver.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/cmp_sweep_pkg.sv
// cmp_sweep_pkg: shared types and helpers for the comparator sweep driver.
//   state_t      - sweep FSM states
//   ERR_CNT_W    - error counter width, ERR_SAT its saturation value
//   idx_to_bus   - interleaves left-aligned A/B operands, MSB pair at bits [1:0]
//   exp_flags    - reference {gt,lt,eq} for an operand pair
package cmp_sweep_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, FIN} state_t;

  localparam int             ERR_CNT_W = 8;
  localparam logic [7:0]     ERR_SAT   = 8'hFF;

  // Widest operand the helpers handle; callers left-align narrower operands
  // so the interleave loop needs no width-dependent indexing.
  localparam int             MAX_OPW   = 8;

  // bus[2i] = A[msb-i], bus[2i+1] = B[msb-i] with operands left-aligned, so
  // the low 2*OPW bits are the interleaved bus for any OPW <= MAX_OPW.
  function automatic logic [2*MAX_OPW-1:0] idx_to_bus(input logic [MAX_OPW-1:0] a_al,
                                                      input logic [MAX_OPW-1:0] b_al);
    logic [2*MAX_OPW-1:0] bus;
    bus = '0;
    for (int i = 0; i < MAX_OPW; i++) begin
      bus[2*i]   = a_al[MAX_OPW-1-i];
      bus[2*i+1] = b_al[MAX_OPW-1-i];
    end
    return bus;
  endfunction

  function automatic logic [2:0] exp_flags(input logic [MAX_OPW-1:0] a,
                                           input logic [MAX_OPW-1:0] b);
    return {a > b, a < b, a == b};
  endfunction

endpackage

// File: rtl/cmp_flag_sync.sv
// cmp_flag_sync: 2-flop synchronizer for the comparator flag bundle.
//   clk, rst_n - clock, async active-low reset (flops reset to 0)
//   d          - asynchronous flag inputs
//   q          - synchronized flags, two cycles behind d
module cmp_flag_sync #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cmp_sweep_driver.sv
// cmp_sweep_driver: exhaustive stimulus/check initiator for an interleaved
// magnitude comparator. On start it walks every A/B pair, waits a settle
// window per vector, samples gt/lt/eq and scores them against a reference.
//   clk, rst_n         - clock, async active-low reset
//   start              - level, accepted in IDLE or FIN
//   cmp_bus            - registered interleaved operands (MSB pair at [1:0])
//   cmp_gt/lt/eq       - comparator flags
//   busy, done, pass   - sweep status; pass valid while done
//   err_cnt            - failing-vector count, saturating at 255
//   fail_a, fail_b     - operands of the first failing vector (0 if none)
// Build option: define CMP_SWEEP_SYNC_EN to pass the flags through a 2-flop
// synchronizer; the settle window grows by two cycles to cover it.
module cmp_sweep_driver
  import cmp_sweep_pkg::*;
#(
  parameter int OPW        = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [2*OPW-1:0]     cmp_bus,
  input  logic                 cmp_gt,
  input  logic                 cmp_lt,
  input  logic                 cmp_eq,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [OPW-1:0]       fail_a,
  output logic [OPW-1:0]       fail_b
);

  localparam int IW = 2*OPW;
  localparam int CW = 5;
`ifdef CMP_SWEEP_SYNC_EN
  localparam int SETTLE_EFF = SETTLE_CYC + 2;
`else
  localparam int SETTLE_EFF = SETTLE_CYC;
`endif

  state_t               state, state_nxt;
  logic [IW-1:0]        idx;
  logic [CW-1:0]        cnt;
  logic                 accept;

  // ---------------- flag capture ----------------
  logic [2:0] flags_raw, flags;
  assign flags_raw = {cmp_gt, cmp_lt, cmp_eq};

`ifdef CMP_SWEEP_SYNC_EN
  cmp_flag_sync #(.W(3)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (flags_raw),
    .q     (flags)
  );
`else
  assign flags = flags_raw;
`endif

  // ---------------- vector decode / reference ----------------
  logic [OPW-1:0] cur_a, cur_b, nxt_a, nxt_b;
  logic [IW-1:0]  idx_nxt;
  logic [2:0]     flags_exp;
  logic           mismatch, last, settle_done;
  logic [ERR_CNT_W-1:0] err_inc;
  logic [2*MAX_OPW-1:0] bus_full;
  logic [IW-1:0]        bus_nxt;
  logic                 unused_bus_hi;

  assign cur_a       = idx[IW-1:OPW];
  assign cur_b       = idx[OPW-1:0];
  assign idx_nxt     = idx + 1'b1;
  assign nxt_a       = idx_nxt[IW-1:OPW];
  assign nxt_b       = idx_nxt[OPW-1:0];
  assign flags_exp   = exp_flags(MAX_OPW'(cur_a), MAX_OPW'(cur_b));
  // Any deviation (wrong flag, none, or several) is one failing vector.
  assign mismatch    = (flags != flags_exp);
  // Terminal vector is detected before increment so idx never wraps.
  assign last        = &idx;
  assign settle_done = (cnt == CW'(SETTLE_EFF - 1));
  assign err_inc     = (err_cnt == ERR_SAT) ? err_cnt : err_cnt + 1'b1;

  assign bus_full      = idx_to_bus(MAX_OPW'(nxt_a) << (MAX_OPW - OPW),
                                    MAX_OPW'(nxt_b) << (MAX_OPW - OPW));
  assign bus_nxt       = bus_full[IW-1:0];
  assign unused_bus_hi = ^bus_full;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, FIN: if (start) begin
        accept    = 1'b1;
        state_nxt = SETTLE;
      end
      SETTLE:    if (settle_done) state_nxt = CHECK;
      CHECK:     state_nxt = last ? FIN : SETTLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      cnt     <= '0;
      cmp_bus <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= '0;
      fail_a  <= '0;
      fail_b  <= '0;
    end else if (accept) begin
      idx     <= '0;
      cnt     <= '0;
      cmp_bus <= '0;
      busy    <= 1'b1;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= '0;
      fail_a  <= '0;
      fail_b  <= '0;
    end else if (state == SETTLE) begin
      cnt <= cnt + 1'b1;
    end else if (state == CHECK) begin
      if (mismatch) begin
        err_cnt <= err_inc;
        // err_cnt never returns to 0 within a sweep, so zero marks "first".
        if (err_cnt == '0) begin
          fail_a <= cur_a;
          fail_b <= cur_b;
        end
      end
      if (last) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= !mismatch && (err_cnt == '0);
      end else begin
        idx     <= idx_nxt;
        cmp_bus <= bus_nxt;
        cnt     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cmp_sweep_driver.sv
module tb_cmp_sweep_driver;

`ifdef CMP_SWEEP_SYNC_EN
  localparam int P = 5;
`else
  localparam int P = 3;
`endif
  localparam int NV    = 256;
  localparam int TOTAL = NV * P;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [7:0] cmp_bus;
  logic       cmp_gt, cmp_lt, cmp_eq;
  logic       busy, done, pass;
  logic [7:0] err_cnt;
  logic [3:0] fail_a, fail_b;

  int checks = 0;
  int errors = 0;
  int mode   = 0;
  logic [2:0] corrupt [NV];

  always #5 clk = ~clk;

  cmp_sweep_driver #(.OPW(4), .SETTLE_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmp_bus(cmp_bus),
    .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_a(fail_a), .fail_b(fail_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Ideal comparator result for vector number i (A = high nibble, B = low).
  function automatic logic [2:0] ideal(input int i);
    int a, b;
    a = i / 16;
    b = i % 16;
    return {a > b, a < b, a == b};
  endfunction

  // Comparator behaviour under each fault mode.
  function automatic logic [2:0] model_flags(input int m, input int i);
    logic [2:0] f;
    f = ideal(i);
    case (m)
      1:       f[0] = 1'b0;            // eq stuck at 0
      2:       f = {f[1], f[2], f[0]}; // gt/lt swapped
      3:       f = 3'b111;             // all stuck at 1
      4:       f = f ^ corrupt[i];     // random per-vector faults
      default: ;
    endcase
    return f;
  endfunction

  function automatic logic [7:0] exp_bus(input int i);
    logic [3:0] a, b;
    logic [7:0] r;
    a = 4'(i / 16);
    b = 4'(i % 16);
    for (int k = 0; k < 4; k++) begin
      r[2*k]   = a[3-k];
      r[2*k+1] = b[3-k];
    end
    return r;
  endfunction

  function automatic int bus_to_vec(input logic [7:0] bus);
    int a, b;
    a = 0;
    b = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus[2*k])   a += 1 << (3-k);
      if (bus[2*k+1]) b += 1 << (3-k);
    end
    return a * 16 + b;
  endfunction

  // Comparator under test, driven from the bus.
  always_comb {cmp_gt, cmp_lt, cmp_eq} = model_flags(mode, bus_to_vec(cmp_bus));

  task automatic run_sweep(input int m, input bit toggle);
    int nerr, first, c, bus_bad;
    mode  = m;
    nerr  = 0;
    first = -1;
    for (int i = 0; i < NV; i++)
      if (model_flags(m, i) != ideal(i)) begin
        nerr++;
        if (first < 0) first = i;
      end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk($sformatf("m%0d_done_clr", m), done, 0);
    chk($sformatf("m%0d_err_clr", m), err_cnt, 0);
    c = 0;
    bus_bad = 0;
    while (busy === 1'b1 && c < 3000) begin
      if (cmp_bus !== exp_bus(c / P)) bus_bad++;
      if (c == 'hA5 * P && !toggle) chk("probe_bus_a5", cmp_bus, 8'h99);
      if (toggle) start = (c < TOTAL - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      c++;
      @(negedge clk);
    end
    start = 1'b0;
    chk($sformatf("m%0d_busy_cycles", m), c, TOTAL);
    chk($sformatf("m%0d_bus_seq_bad", m), bus_bad, 0);
    chk($sformatf("m%0d_done", m), done, 1);
    chk($sformatf("m%0d_pass", m), pass, (nerr == 0));
    chk($sformatf("m%0d_err_cnt", m), err_cnt, (nerr > 255) ? 255 : nerr);
    chk($sformatf("m%0d_fail_a", m), fail_a, (first < 0) ? 0 : first / 16);
    chk($sformatf("m%0d_fail_b", m), fail_b, (first < 0) ? 0 : first % 16);
    repeat (4) @(negedge clk);
    chk($sformatf("m%0d_done_hold", m), {busy, done}, 2'b01);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_bus"},  cmp_bus, 0);
    chk({tag, "_stat"}, {busy, done, pass}, 0);
    chk({tag, "_err"},  err_cnt, 0);
    chk({tag, "_fail"}, {fail_a, fail_b}, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < NV; i++) corrupt[i] = 3'b000;
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_stat", {busy, done}, 0);

    run_sweep(0, 0);
    run_sweep(1, 0);
    run_sweep(2, 0);
    run_sweep(3, 0);

    for (int r = 0; r < 3; r++) begin
      int pct;
      pct = (r == 2) ? 100 : 10;
      for (int i = 0; i < NV; i++)
        corrupt[i] = ($urandom_range(0, 99) < pct) ? 3'($urandom_range(1, 7)) : 3'b000;
      run_sweep(4, 0);
    end

    run_sweep(0, 1);

    // Mid-sweep reset: make errors visible first so a retained result shows.
    mode = 3;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (300) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_idle", {busy, done}, 0);
    run_sweep(0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
